// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code decoding.
// Used by the decoder top and the combinational code checker.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam int ERR_W = 8;

    function automatic int next_idx(input int prev, input int n);
        return (prev + 1 >= 2 * n) ? 0 : prev + 1;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code checker: legality flag and binary index.
// Index is meaningful only when o_legal is set.
module johnson_code_check #(
    parameter int N  = 3,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  i_code,
    output logic          o_legal,
    output logic [IW-1:0] o_idx
);

    logic [N-2:0]  w_diff;
    logic [IW-1:0] w_pc;

    // A Johnson code has at most one 0/1 boundary between adjacent stages
    assign w_diff  = i_code[N-1:1] ^ i_code[N-2:0];
    assign o_legal = ((w_diff & (w_diff - 1'b1)) == '0);

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < N; i++) begin
            w_pc = w_pc + IW'(i_code[i]);
        end
    end

    assign o_idx = i_code[N-1] ? (IW'(2 * N) - w_pc) : w_pc;

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-count decoder with lock qualification, step checking
// and a saturating error counter.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N          = 3,
    parameter int LOCK_CNT   = 4,
    parameter int ALLOW_HOLD = 1,
    localparam int IW        = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     code,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [IW-1:0]    idx,
    output logic [2*N-1:0]   onehot,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] LC = 4'(LOCK_CNT);

    lock_state_t r_state;
    lock_state_t w_state_nxt;

    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [IW-1:0]    r_prev;
    logic [IW-1:0]    r_idx;
    logic [2*N-1:0]   r_onehot;
    logic             r_out_valid;
    logic             r_code_err;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;

    logic             w_legal;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_succ;
    logic             w_step_ok;
    logic [2*N-1:0]   w_onehot;
    logic             w_code_err;
    logic             w_seq_err;
    logic             w_err_evt;

    johnson_code_check #(
        .N  (N),
        .IW (IW)
    ) u_check (
        .i_code  (code),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    assign w_succ    = IW'(next_idx(int'(r_prev), N));
    assign w_step_ok = (w_idx == w_succ) ||
                       ((ALLOW_HOLD != 0) && (w_idx == r_prev));

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < 2 * N; i++) begin
            w_onehot[i] = (w_idx == IW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_code_err  = 1'b0;
        w_seq_err   = 1'b0;
        w_err_evt   = 1'b0;
        if (in_valid) begin
            w_code_err = !w_legal;
            unique case (r_state)
                UNLOCKED: begin
                    if (w_legal) begin
                        w_run_nxt   = 4'd1;
                        w_state_nxt = (LC == 4'd1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (w_legal && w_step_ok) begin
                        w_run_nxt = r_run + 4'd1;
                        if (w_run_nxt >= LC) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_run_nxt   = 4'd0;
                        w_state_nxt = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!w_legal || !w_step_ok) begin
                        w_seq_err   = w_legal;
                        w_err_evt   = 1'b1;
                        w_run_nxt   = 4'd0;
                        w_state_nxt = UNLOCKED;
                    end
                end
                default: begin
                    w_run_nxt   = 4'd0;
                    w_state_nxt = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= UNLOCKED;
            r_run   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Illegal codes leave idx and the step reference untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_code_err  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_prev      <= '0;
            r_idx       <= '0;
            r_onehot    <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_code_err  <= w_code_err;
            r_seq_err   <= w_seq_err;
            if (in_valid && w_legal) begin
                r_prev   <= w_idx;
                r_idx    <= w_idx;
                r_onehot <= w_onehot;
            end else if (in_valid) begin
                r_onehot <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= w_err_evt ? ERR_W'(1) : '0;
        end else if (w_err_evt && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign idx       = r_idx;
    assign onehot    = r_onehot;
    assign code_err  = r_code_err;
    assign seq_err   = r_seq_err;
    assign locked    = (r_state == LOCKED);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder, N=3, LOCK_CNT=4.
// Two instances differ only in ALLOW_HOLD and share the stimulus.
module tb_johnson_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] code;
    logic       clr_err;

    logic       a_ov, a_ce, a_se, a_lk;
    logic [2:0] a_idx;
    logic [5:0] a_oh;
    logic [7:0] a_ec;

    logic       b_ov, b_ce, b_se, b_lk;
    logic [2:0] b_idx;
    logic [5:0] b_oh;
    logic [7:0] b_ec;

    int nchk;
    int nerr;
    int cur;

    logic [2:0] jc [6];

    johnson_decoder #(
        .N          (3),
        .LOCK_CNT   (4),
        .ALLOW_HOLD (1)
    ) dut_hold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .code      (code),
        .clr_err   (clr_err),
        .out_valid (a_ov),
        .idx       (a_idx),
        .onehot    (a_oh),
        .code_err  (a_ce),
        .seq_err   (a_se),
        .locked    (a_lk),
        .err_count (a_ec)
    );

    johnson_decoder #(
        .N          (3),
        .LOCK_CNT   (4),
        .ALLOW_HOLD (0)
    ) dut_nohold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .code      (code),
        .clr_err   (clr_err),
        .out_valid (b_ov),
        .idx       (b_idx),
        .onehot    (b_oh),
        .code_err  (b_ce),
        .seq_err   (b_se),
        .locked    (b_lk),
        .err_count (b_ec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c,
                        input logic clr);
        in_valid = v;
        code     = c;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_legal(input string tag, input int e_idx,
                             input logic e_lk);
        chk({tag, "_ov"}, 32'(a_ov), 32'd1);
        chk({tag, "_idx"}, 32'(a_idx), 32'(e_idx));
        chk({tag, "_oh"}, 32'(a_oh), 32'(1) << e_idx);
        chk({tag, "_lk"}, 32'(a_lk), 32'(e_lk));
        chk({tag, "_err"}, {30'd0, a_ce, a_se}, 32'd0);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        jc[0] = 3'b000; jc[1] = 3'b001; jc[2] = 3'b011;
        jc[3] = 3'b111; jc[4] = 3'b110; jc[5] = 3'b100;

        reset    = 1'b1;
        in_valid = 1'b0;
        code     = 3'b000;
        clr_err  = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_oh", 32'(a_oh), 32'd0);
        chk("rst_ov", 32'(a_ov), 32'd0);
        chk("rst_lk", 32'(a_lk), 32'd0);
        chk("rst_ec", 32'(a_ec), 32'd0);
        chk("rst_pulse", {30'd0, a_ce, a_se}, 32'd0);
        reset = 1'b1;

        // full sequence with wrap, lock after 4th sample
        step(1, 3'b000, 0); chk_legal("seq0", 0, 0);
        step(1, 3'b001, 0); chk_legal("seq1", 1, 0);
        step(1, 3'b011, 0); chk_legal("seq2", 2, 0);
        step(1, 3'b111, 0); chk_legal("seq3", 3, 1);
        step(1, 3'b110, 0); chk_legal("seq4", 4, 1);
        step(1, 3'b100, 0); chk_legal("seq5", 5, 1);
        step(1, 3'b000, 0); chk_legal("seq6", 0, 1);

        // illegal code while locked at idx 2
        step(1, 3'b001, 0);
        step(1, 3'b011, 0); chk_legal("pre_ce", 2, 1);
        step(1, 3'b101, 0);
        chk("ce_pulse", 32'(a_ce), 32'd1);
        chk("ce_oh", 32'(a_oh), 32'd0);
        chk("ce_idx", 32'(a_idx), 32'd2);
        chk("ce_lk", 32'(a_lk), 32'd0);
        chk("ce_ec", 32'(a_ec), 32'd1);
        step(0, 3'b000, 0);
        chk("ce_clear", 32'(a_ce), 32'd0);
        chk("idle_ov", 32'(a_ov), 32'd0);

        // relock, then skip from idx 3 to idx 5
        step(1, 3'b111, 0);
        step(1, 3'b110, 0);
        step(1, 3'b100, 0);
        step(1, 3'b000, 0); chk_legal("relock_a", 0, 1);
        step(1, 3'b001, 0);
        step(1, 3'b011, 0);
        step(1, 3'b111, 0); chk_legal("pre_se", 3, 1);
        step(0, 3'b000, 1);
        chk("clr_ec", 32'(a_ec), 32'd0);
        step(1, 3'b100, 0);
        chk("se_pulse", 32'(a_se), 32'd1);
        chk("se_ce", 32'(a_ce), 32'd0);
        chk("se_idx", 32'(a_idx), 32'd5);
        chk("se_lk", 32'(a_lk), 32'd0);
        chk("se_ec", 32'(a_ec), 32'd1);
        step(1, 3'b000, 0); chk_legal("rl0", 0, 0);
        step(1, 3'b001, 0); chk_legal("rl1", 1, 0);
        step(1, 3'b011, 0); chk_legal("rl2", 2, 0);
        step(1, 3'b111, 0); chk_legal("rl3", 3, 1);

        // repeated index: legal only when holds are allowed
        step(1, 3'b110, 0);
        step(1, 3'b100, 0);
        step(1, 3'b000, 0);
        step(1, 3'b001, 0);
        chk("hold_pre_lk_b", 32'(b_lk), 32'd1);
        step(1, 3'b001, 0);
        chk_legal("hold_a", 1, 1);
        chk("hold_a_ec", 32'(a_ec), 32'd1);
        chk("hold_b_se", 32'(b_se), 32'd1);
        chk("hold_b_lk", 32'(b_lk), 32'd0);
        chk("hold_b_idx", 32'(b_idx), 32'd1);
        chk("hold_b_ec", 32'(b_ec), 32'd2);

        // asynchronous reset mid-cycle while locked
        step(1, 3'b011, 0);
        chk("ar_pre_lk", 32'(a_lk), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_lk", 32'(a_lk), 32'd0);
        chk("ar_idx", 32'(a_idx), 32'd0);
        chk("ar_oh", 32'(a_oh), 32'd0);
        chk("ar_ov", 32'(a_ov), 32'd0);
        chk("ar_ec", 32'(a_ec), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 3'b011, 0); chk_legal("ar0", 2, 0);
        step(1, 3'b111, 0); chk_legal("ar1", 3, 0);
        step(1, 3'b110, 0); chk_legal("ar2", 4, 0);
        step(1, 3'b100, 0); chk_legal("ar3", 5, 1);

        // saturate the error counter with locked code errors
        cur = 5;
        for (int e = 0; e < 260; e++) begin
            step(1, 3'b101, 0);
            for (int k = 0; k < 4; k++) begin
                cur = (cur + 1) % 6;
                step(1, jc[cur], 0);
            end
            if (e == 9) chk("cnt10", 32'(a_ec), 32'd10);
        end
        chk("sat_lk", 32'(a_lk), 32'd1);
        chk("sat_a", 32'(a_ec), 32'd255);
        chk("sat_b", 32'(b_ec), 32'd255);

        // clear and error in the same cycle
        step(1, 3'b101, 1);
        chk("clr_evt_ec", 32'(a_ec), 32'd1);
        chk("clr_evt_ce", 32'(a_ce), 32'd1);
        step(0, 3'b000, 0);
        chk("clr_evt_hold", 32'(a_ec), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Decodes an N-bit Johnson (twisted-ring) count presented on a parallel bus into a binary index and a one-hot state vector, and checks every sample for illegal codes and illegal step sequences. It sits on the receiving side of the team's Johnson counters. It lets downstream logic consume the counter state directly and flags corruption or skipped states. A small lock state machine qualifies the stream before errors are treated as real.

## Interface
- N, 3: Johnson code width in bits; the sequence has 2N states; N >= 2.
- LOCK_CNT, 4: consecutive legal samples needed to enter LOCKED; 1..15.
- ALLOW_HOLD, 1: 1 = a repeated index is a legal step; 0 = every valid sample must advance.
- IW, $clog2(2N): index width (derived, not overridden).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  code is sampled this cycle.
- code  in  N  Johnson code; bit 0 is the stage fed by the inverted MSB.
- clr_err  in  1  synchronous clear of err_count.
- out_valid  out  1  registered copy of in_valid.
- idx  out  IW  decoded index 0..2N-1 of the last legal code.
- onehot  out  2N  bit idx set for a legal sample; all zero for an illegal one.
- code_err  out  1  one-cycle pulse: sampled code is not a Johnson code.
- seq_err  out  1  one-cycle pulse: legal code but illegal step while LOCKED.
- locked  out  1  FSM is in LOCKED.
- err_count  out  8  saturating count of code_err plus seq_err events.

## Operation
- Legality: code is legal iff code[N-1:1] ^ code[N-2:0] has at most one bit set. For N=3, 010 and 101 are illegal.
- Index for a legal code: if code[N-1]=0, idx = popcount(code); otherwise idx = 2N - popcount(code).
  - N=3 sequence: 000→0, 001→1, 011→2, 111→3, 110→4, 100→5.
- Step rule: next = (prev+1) mod 2N is legal. next = prev is legal iff ALLOW_HOLD. Wrap 2N-1→0 is legal.
- FSM states:
  - UNLOCKED: a legal sample goes to ACQUIRE with run=1.
  - ACQUIRE: a legal sample with a legal step increments run. When run reaches LOCK_CNT, go to LOCKED. An illegal code or bad step goes to UNLOCKED with run=0, and no error pulses are raised. If LOCK_CNT=1, UNLOCKED goes directly to LOCKED.
  - LOCKED: an illegal code raises code_err; a bad step raises seq_err. Either one goes to UNLOCKED and increments err_count.
- code_err is also raised in UNLOCKED and ACQUIRE, but err_count increments only from LOCKED.
- Illegal code: idx holds its last legal value, onehot = 0, and prev is not updated.
- in_valid=0: no state change, and all pulses are 0.
- err_count saturates at 255. If clr_err and an error occur in the same cycle, the result is 1.

## Timing
- All outputs are registered, with one-cycle latency from the in_valid/code sample to out_valid/idx/onehot/pulses/locked.
- Reset (reset=0, asynchronous):
  - outputs: idx=0, onehot=0, out_valid=0, code_err=0, seq_err=0, locked=0, err_count=0;
  - internal: FSM=UNLOCKED, run=0, prev=0.
- Deassertion of reset is taken synchronously. The first sample is accepted on the first rising edge with reset=1.
- Reset asserted mid-stream aborts acquisition immediately. Lock must be re-earned with LOCK_CNT new samples.
- Throughput: one sample per clock, with no backpressure.

## Structure
- Package johnson_pkg holds:
  - the FSM state enum: UNLOCKED, ACQUIRE, LOCKED;
  - the err_count width constant (8);
  - function next_idx(prev, N), which computes (prev+1) mod 2N.
- Sub-module johnson_code_check is purely combinational: code → legal, idx. It is reused by future Johnson-counter monitors.
- The top level contains the sample register, the FSM, the step compare and the error counter.

## Test plan
- Reset, then feed the N=3 sequence 000,001,011,111,110,100,000 one per cycle → idx 0,1,2,3,4,5,0 one cycle later; locked rises on the cycle after the 4th sample; no error pulses.
- While LOCKED at idx=2, inject 101 → code_err=1 for one cycle, onehot=0, idx stays 2, locked=0, err_count=1.
- While LOCKED at idx=3, inject 100 (idx 5, a skip) → seq_err=1, locked=0, err_count=1; then re-lock after 4 legal steps.
- ALLOW_HOLD=0: LOCKED at idx=1, repeat 001 → seq_err pulse. With ALLOW_HOLD=1, the same stimulus produces no error.
- Force 256+ LOCKED errors → err_count stays at 255; assert clr_err in the same cycle as an error → err_count=1.
- Assert reset asynchronously mid-cycle while LOCKED → outputs go to zero before the next edge; after release, locked stays 0 for 4 samples.
